axi_llc_evict_wb_seq: RTL and testbench
=======================================

# axi_llc_evict_wb_seq

Consumer of the LLC way-selection decision: accepts one eviction descriptor (one-hot way, dirty-evict flag, index, old tag) and, when the old line is dirty, sequences its write-back by issuing one AXI AW descriptor, streaming per-beat data-storage read requests and waiting for the B response. It then releases the descriptor to the refill path. It sits between the hit/miss detection unit and the write-back / refill channel units.

## Interface
- SetAssociativity, 8: number of ways; width of the one-hot way indicator.
- IndexWidth, 8: set index width.
- TagWidth, 16: tag width.
- NumBlocks, 4: beats per cache line, power of two, >= 1.
- ByteOffset, 3: log2 of bytes per beat.
- AddrWidth, TagWidth+IndexWidth+$clog2(NumBlocks)+ByteOffset: AXI address width, fixed by the other parameters.
- clk_i  in  1  clock, positive edge.
- rst_ni  in  1  reset; one clock, reset is synchronous and active-low.
- desc_valid_i / desc_ready_o  in/out  1  descriptor handshake.
- desc_way_ind_i  in  SetAssociativity  one-hot way to replace.
- desc_evict_i  in  1  old line is dirty and must be written back.
- desc_index_i  in  IndexWidth  set index.
- desc_tag_i  in  TagWidth  tag of the line being evicted.
- aw_valid_o / aw_ready_i  out/in  1  write-back AW handshake.
- aw_addr_o  out  AddrWidth  {tag, index, zero offset}.
- aw_len_o  out  8  NumBlocks-1.
- rd_valid_o / rd_ready_i  out/in  1  data-storage read request handshake.
- rd_way_o  out  $clog2(SetAssociativity) (min 1)  binary-encoded way.
- rd_index_o  out  IndexWidth  set index.
- rd_beat_o  out  $clog2(NumBlocks) (min 1)  beat number.
- b_valid_i / b_ready_o  in/out  1  write response handshake.
- b_err_i  in  1  B response was SLVERR/DECERR.
- refill_valid_o / refill_ready_i  out/in  1  released descriptor handshake.
- refill_way_ind_o  out  SetAssociativity  captured one-hot way.
- refill_index_o  out  IndexWidth  captured index.
- refill_wb_err_o  out  1  write-back of this descriptor got an error response.
- busy_o  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, AW, READ, WAIT_B, REFILL.
- IDLE: desc_ready_o=1. On desc_valid_i: capture way, evict, index, tag; clear err flag; go AW if desc_evict_i else REFILL.
- AW: aw_valid_o=1, address/len stable from captured regs; on aw_ready_i -> READ, beat counter = 0.
- READ: rd_valid_o=1, rd_beat_o = counter; on rd_ready_i counter+1; on handshake with counter == NumBlocks-1 -> WAIT_B, counter wraps to 0.
- WAIT_B: b_ready_o=1; on b_valid_i capture b_err_i into err flag -> REFILL.
- REFILL: refill_valid_o=1, outputs from captured regs; on refill_ready_i -> IDLE.
- Way encode: one-hot to binary, lowest set bit wins; non-one-hot input is a protocol violation (assertion, excluded from translate).
- All handshake outputs only depend on state (no combinational input-to-valid paths); valid never drops before its ready.

## Timing
- Reset (rst_ni=0 at a rising edge): state IDLE, counter 0, captured regs 0. Outputs after reset: desc_ready_o=1, all other valids/readies 0, busy_o=0, data outputs 0.
- Reset mid-operation aborts the sequence immediately; no further AW/read/refill for the aborted descriptor.
- Clean miss: descriptor accepted cycle 0, refill_valid_o high cycle 1.
- Dirty miss, all readies high, B at earliest: AW cycle 1, reads cycles 2..NumBlocks+1, b_ready_o from cycle NumBlocks+2, refill_valid_o one cycle after B handshake.
- b_valid_i outside WAIT_B is ignored (b_ready_o=0). Only one descriptor in flight; throughput one descriptor per at least 2 cycles (IDLE→REFILL→IDLE).
- NumBlocks=1: READ issues one request, counter width 1, stays 0.

## Test plan
- Reset: hold rst_ni=0 2 cycles mid-READ -> next cycle state IDLE, desc_ready_o=1, rd_valid_o=0, busy_o=0.
- Clean miss: way=8'b0000_0100, evict=0, index=0x3A -> no AW/rd; refill_valid_o at cycle 1 with way 0x04, index 0x3A, wb_err 0.
- Dirty evict: way=8'b1000_0000, tag=0xBEEF, index=0x12, all ready -> aw_addr_o={0xBEEF,0x12,5'b0}, aw_len_o=3; rd_way_o=7, beats 0,1,2,3 on consecutive cycles; refill after B.
- Backpressure: aw_ready_i low 3 cycles, rd_ready_i toggling -> aw/rd valid held, addr/beat stable, exactly 4 read handshakes.
- Error B: b_err_i=1 on B -> refill_wb_err_o=1; next clean descriptor -> refill_wb_err_o=0.
- Refill stall: refill_ready_i low 5 cycles -> refill_valid_o held, desc_ready_o=0, incoming descriptor not captured until IDLE.

Source files
------------

// File: rtl/axi_llc_evict_wb_seq.sv
// LLC eviction write-back sequencer: takes one eviction descriptor at a time,
// writes the dirty victim line back over AXI (AW, per-beat data reads, B), then
// hands the descriptor on to the refill path.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   desc_*                 eviction descriptor in (valid/ready, way, evict, index, tag)
//   aw_*                   write-back address channel out (valid/ready, addr, len)
//   rd_*                   data-storage read requests out (valid/ready, way, index, beat)
//   b_*                    write response in (valid/ready, err)
//   refill_*               released descriptor out (valid/ready, way, index, wb_err)
//   busy_o                 sequencer is not idle
module axi_llc_evict_wb_seq #(
    parameter int unsigned SetAssociativity = 8,
    parameter int unsigned IndexWidth       = 8,
    parameter int unsigned TagWidth         = 16,
    parameter int unsigned NumBlocks        = 4,
    parameter int unsigned ByteOffset       = 3,
    parameter int unsigned AddrWidth        =
        TagWidth + IndexWidth + $clog2(NumBlocks) + ByteOffset,
    localparam int unsigned WayWidth  =
        (SetAssociativity > 1) ? $clog2(SetAssociativity) : 1,
    localparam int unsigned BeatWidth =
        (NumBlocks > 1) ? $clog2(NumBlocks) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        desc_valid_i,
    output logic                        desc_ready_o,
    input  logic [SetAssociativity-1:0] desc_way_ind_i,
    input  logic                        desc_evict_i,
    input  logic [IndexWidth-1:0]       desc_index_i,
    input  logic [TagWidth-1:0]         desc_tag_i,

    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [AddrWidth-1:0]        aw_addr_o,
    output logic [7:0]                  aw_len_o,

    output logic                        rd_valid_o,
    input  logic                        rd_ready_i,
    output logic [WayWidth-1:0]         rd_way_o,
    output logic [IndexWidth-1:0]       rd_index_o,
    output logic [BeatWidth-1:0]        rd_beat_o,

    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    input  logic                        b_err_i,

    output logic                        refill_valid_o,
    input  logic                        refill_ready_i,
    output logic [SetAssociativity-1:0] refill_way_ind_o,
    output logic [IndexWidth-1:0]       refill_index_o,
    output logic                        refill_wb_err_o,

    output logic                        busy_o
);

    localparam int unsigned OffWidth = AddrWidth - TagWidth - IndexWidth;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        READ,
        WAIT_B,
        REFILL
    } state_e;

    state_e                      state_q, state_d;
    logic [BeatWidth-1:0]        cnt_q, cnt_d;
    logic [SetAssociativity-1:0] way_q, way_d;
    logic [IndexWidth-1:0]       index_q, index_d;
    logic [TagWidth-1:0]         tag_q, tag_d;
    logic                        err_q, err_d;
    logic [WayWidth-1:0]         way_enc;
    logic                        last_beat;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            way_q   <= '0;
            index_q <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            way_q   <= way_d;
            index_q <= index_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
        end
    end

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        way_enc = '0;
        for (int i = SetAssociativity - 1; i >= 0; i--) begin
            if (way_q[i]) begin
                way_enc = WayWidth'(i);
            end
        end
    end

    assign last_beat = (cnt_q == BeatWidth'(NumBlocks - 1));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        way_d          = way_q;
        index_d        = index_q;
        tag_d          = tag_q;
        err_d          = err_q;
        desc_ready_o   = 1'b0;
        aw_valid_o     = 1'b0;
        rd_valid_o     = 1'b0;
        b_ready_o      = 1'b0;
        refill_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    way_d   = desc_way_ind_i;
                    index_d = desc_index_i;
                    tag_d   = desc_tag_i;
                    err_d   = 1'b0;
                    state_d = desc_evict_i ? AW : REFILL;
                end
            end
            AW: begin
                aw_valid_o = 1'b1;
                if (aw_ready_i) begin
                    state_d = READ;
                    cnt_d   = '0;
                end
            end
            READ: begin
                rd_valid_o = 1'b1;
                if (rd_ready_i) begin
                    if (last_beat) begin
                        state_d = WAIT_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + BeatWidth'(1);
                    end
                end
            end
            WAIT_B: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    err_d   = b_err_i;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                refill_valid_o = 1'b1;
                if (refill_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign aw_addr_o        = {tag_q, index_q, {OffWidth{1'b0}}};
    assign aw_len_o         = 8'(NumBlocks - 1);
    assign rd_way_o         = way_enc;
    assign rd_index_o       = index_q;
    assign rd_beat_o        = cnt_q;
    assign refill_way_ind_o = way_q;
    assign refill_index_o   = index_q;
    assign refill_wb_err_o  = err_q;
    assign busy_o           = (state_q != IDLE);

`ifndef SYNTHESIS
    a_way_onehot: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (desc_valid_i && desc_ready_o) |-> $onehot(desc_way_ind_i)
    );
`endif

endmodule

// File: tb/tb_axi_llc_evict_wb_seq.sv
// Testbench for axi_llc_evict_wb_seq: directed vector table, reset abort
// sequence, and randomized traffic against a transaction-level model.
module tb_axi_llc_evict_wb_seq;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        desc_valid_i, desc_ready_o;
    logic [7:0]  desc_way_ind_i;
    logic        desc_evict_i;
    logic [7:0]  desc_index_i;
    logic [15:0] desc_tag_i;
    logic        aw_valid_o, aw_ready_i;
    logic [28:0] aw_addr_o;
    logic [7:0]  aw_len_o;
    logic        rd_valid_o, rd_ready_i;
    logic [2:0]  rd_way_o;
    logic [7:0]  rd_index_o;
    logic [1:0]  rd_beat_o;
    logic        b_valid_i, b_ready_o, b_err_i;
    logic        refill_valid_o, refill_ready_i;
    logic [7:0]  refill_way_ind_o;
    logic [7:0]  refill_index_o;
    logic        refill_wb_err_o;
    logic        busy_o;

    axi_llc_evict_wb_seq dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_way_ind_i(desc_way_ind_i), .desc_evict_i(desc_evict_i),
        .desc_index_i(desc_index_i), .desc_tag_i(desc_tag_i),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_way_o(rd_way_o), .rd_index_o(rd_index_o), .rd_beat_o(rd_beat_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_err_i(b_err_i),
        .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
        .refill_way_ind_o(refill_way_ind_o), .refill_index_o(refill_index_o),
        .refill_wb_err_o(refill_wb_err_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // {desc_ready, aw_valid, rd_valid, b_ready, refill_valid, busy}
    localparam logic [5:0] S_IDLE = 6'b100000;
    localparam logic [5:0] S_AW   = 6'b010001;
    localparam logic [5:0] S_RD   = 6'b001001;
    localparam logic [5:0] S_B    = 6'b000101;
    localparam logic [5:0] S_RF   = 6'b000011;

    typedef struct {
        logic        dv;
        logic [7:0]  way;
        logic        ev;
        logic [7:0]  idx;
        logic [15:0] tag;
        logic        awr, rdr, bv, be, rfr;
        logic [5:0]  exp_hs;
        logic [1:0]  exp_beat;
        logic        exp_err;
    } vec_t;

    localparam int K_AW = 0;
    localparam int K_RD = 1;
    localparam int K_B  = 2;
    localparam int K_RF = 3;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } ev_t;

    vec_t vecs[$];
    ev_t  mq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_rf  = 0;
    logic m_err;

    logic [7:0]  cur_way;
    logic [7:0]  cur_idx;
    logic [15:0] cur_tag;
    logic [2:0]  cur_bin;

    function automatic logic [5:0] hs();
        return {desc_ready_o, aw_valid_o, rd_valid_o,
                b_ready_o, refill_valid_o, busy_o};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic dv, input logic [7:0] way, input logic ev,
                       input logic [7:0] idx, input logic [15:0] tag,
                       input logic awr, input logic rdr, input logic bv,
                       input logic be, input logic rfr, input logic [5:0] h,
                       input logic [1:0] beat, input logic err);
        vec_t v;
        v.dv = dv; v.way = way; v.ev = ev; v.idx = idx; v.tag = tag;
        v.awr = awr; v.rdr = rdr; v.bv = bv; v.be = be; v.rfr = rfr;
        v.exp_hs = h; v.exp_beat = beat; v.exp_err = err;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic dv, input logic [7:0] way,
                         input logic ev, input logic [7:0] idx,
                         input logic [15:0] tag, input logic awr,
                         input logic rdr, input logic bv, input logic be,
                         input logic rfr);
        desc_valid_i = dv; desc_way_ind_i = way; desc_evict_i = ev;
        desc_index_i = idx; desc_tag_i = tag; aw_ready_i = awr;
        rd_ready_i = rdr; b_valid_i = bv; b_err_i = be;
        refill_ready_i = rfr;
    endtask

    task automatic push_desc(input int sh, input logic ev,
                             input logic [7:0] idx, input logic [15:0] tag);
        ev_t e;
        m_err = 1'b0;
        if (ev) begin
            e.kind = K_AW;
            e.val  = 64'({tag, idx, 5'b0, 8'd3});
            mq.push_back(e);
            for (int b = 0; b < 4; b++) begin
                e.kind = K_RD;
                e.val  = 64'({3'(sh), idx, 2'(b)});
                mq.push_back(e);
            end
            e.kind = K_B;
            e.val  = '0;
            mq.push_back(e);
        end
        e.kind = K_RF;
        e.val  = 64'({8'(1 << sh), idx});
        mq.push_back(e);
    endtask

    task automatic rand_cycle();
        int          sh;
        int          k;
        logic [5:0]  exp_hs;
        sh = $urandom_range(0, 7);
        rst_ni = ($urandom_range(0, 499) != 0);
        drive($urandom_range(0, 1) == 1, 8'(1 << sh),
              $urandom_range(0, 1) == 1, 8'($urandom), 16'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) != 0);
        k = (mq.size() == 0) ? -1 : mq[0].kind;
        exp_hs = {k == -1, k == K_AW, k == K_RD, k == K_B, k == K_RF, k != -1};
        chk("rand_hs", 64'(hs()), 64'(exp_hs));
        if (k == K_AW) chk("rand_aw", 64'({aw_addr_o, aw_len_o}), mq[0].val);
        if (k == K_RD) chk("rand_rd", 64'({rd_way_o, rd_index_o, rd_beat_o}),
                           mq[0].val);
        if (k == K_RF) chk("rand_rf",
                           64'({refill_way_ind_o, refill_index_o, refill_wb_err_o}),
                           {mq[0].val[62:0], m_err});
        if (!rst_ni) begin
            mq.delete();
        end else begin
            if (k == -1 && desc_valid_i)
                push_desc(sh, desc_evict_i, desc_index_i, desc_tag_i);
            else if (k == K_AW && aw_ready_i) void'(mq.pop_front());
            else if (k == K_RD && rd_ready_i) void'(mq.pop_front());
            else if (k == K_B && b_valid_i) begin
                m_err = b_err_i;
                void'(mq.pop_front());
            end else if (k == K_RF && refill_ready_i) begin
                n_rf++;
                void'(mq.pop_front());
            end
        end
        step();
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(0, 8'h0, 0, 8'h0, 16'h0, 0, 0, 0, 0, 0);

        // dirty evict, all ready, stray B in AW ignored, B one cycle late
        add(1, 8'h80, 1, 8'h12, 16'hBEEF, 0, 0, 0, 0, 0, S_IDLE, 0, 0);
        add(0, 8'h00, 0, 8'h00, 16'h0000, 1, 0, 1, 1, 0, S_AW,   0, 0);
        for (int b = 0; b < 4; b++)
            add(0, 8'h00, 0, 8'h00, 16'h0, 0, 1, 0, 0, 0, S_RD, 2'(b), 0);
        add(0, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, S_B,    0, 0);
        add(0, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 1, 0, 0, S_B,    0, 0);
        add(0, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, S_RF,   0, 0);
        // clean miss
        add(1, 8'h04, 0, 8'h3A, 16'h0000, 0, 0, 0, 0, 0, S_IDLE, 0, 0);
        add(0, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, S_RF,   0, 0);
        // backpressure, error B, refill stall with a pending descriptor
        add(1, 8'h02, 1, 8'h55, 16'h1234, 0, 0, 0, 0, 0, S_IDLE, 0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 8'h00, 0, 8'h00, 16'h0, 0, 0, 0, 0, 0, S_AW, 0, 0);
        add(0, 8'h00, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, S_AW,   0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 8'h00, 0, 8'h00, 16'h0, 0, 1'(i % 2), 0, 0, 0, S_RD,
                2'(i / 2), 0);
        add(0, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 1, 1, 0, S_B,    0, 0);
        for (int i = 0; i < 5; i++)
            add(1, 8'h01, 0, 8'h77, 16'h0, 0, 0, 0, 0, 0, S_RF, 0, 1);
        add(0, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, S_RF,   0, 1);
        add(1, 8'h10, 0, 8'h99, 16'h0000, 0, 0, 0, 0, 0, S_IDLE, 0, 0);
        add(0, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, S_RF,   0, 0);
        add(0, 8'h00, 0, 8'h00, 16'h0000, 1, 1, 1, 1, 1, S_IDLE, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_hs", 64'(hs()), 64'(S_IDLE));
        chk("reset_data", 64'({aw_addr_o, rd_way_o, refill_way_ind_o,
                               refill_index_o, refill_wb_err_o}), 64'(0));
        rst_ni = 1'b1;

        cur_way = '0; cur_idx = '0; cur_tag = '0; cur_bin = '0;
        foreach (vecs[r]) begin
            drive(vecs[r].dv, vecs[r].way, vecs[r].ev, vecs[r].idx,
                  vecs[r].tag, vecs[r].awr, vecs[r].rdr, vecs[r].bv,
                  vecs[r].be, vecs[r].rfr);
            chk($sformatf("vec%0d_hs", r), 64'(hs()), 64'(vecs[r].exp_hs));
            if (vecs[r].exp_hs == S_AW)
                chk($sformatf("vec%0d_aw", r), 64'({aw_addr_o, aw_len_o}),
                    64'({cur_tag, cur_idx, 5'b0, 8'd3}));
            if (vecs[r].exp_hs == S_RD)
                chk($sformatf("vec%0d_rd", r),
                    64'({rd_way_o, rd_index_o, rd_beat_o}),
                    64'({cur_bin, cur_idx, vecs[r].exp_beat}));
            if (vecs[r].exp_hs == S_RF)
                chk($sformatf("vec%0d_rf", r),
                    64'({refill_way_ind_o, refill_index_o, refill_wb_err_o}),
                    64'({cur_way, cur_idx, vecs[r].exp_err}));
            if (vecs[r].dv && vecs[r].exp_hs == S_IDLE) begin
                cur_way = vecs[r].way;
                cur_idx = vecs[r].idx;
                cur_tag = vecs[r].tag;
                for (int i = 7; i >= 0; i--)
                    if (cur_way[i]) cur_bin = 3'(i);
            end
            step();
        end

        // reset held two cycles in the middle of the read burst
        drive(1, 8'h08, 1, 8'h21, 16'hCAFE, 1, 1, 0, 0, 1);
        step();
        desc_valid_i = 1'b0;
        step();
        step();
        chk("pre_rst_rd", 64'({hs(), rd_beat_o}), 64'({S_RD, 2'd1}));
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        chk("rst_abort_hs", 64'(hs()), 64'(S_IDLE));
        chk("rst_abort_addr", 64'(aw_addr_o), 64'(0));
        for (int i = 0; i < 6; i++) begin
            drive(0, 8'h0, 0, 8'h0, 16'h0, 1, 1, 1, 0, 1);
            chk($sformatf("rst_quiet%0d", i), 64'(hs()), 64'(S_IDLE));
            step();
        end

        m_err = 1'b0;
        for (int c = 0; c < 4000; c++) rand_cycle();
        chk("rand_refills_seen", 64'(n_rf >= 50), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
